// File: rtl/bimodal_pht.sv
// ---------------------------------------------------------------------------
// bimodal_pht
// Bimodal pattern history table of 2-bit saturating branch counters.
// A lookup issued in one cycle returns the counter read for that PC in the
// next cycle. A resolved-branch update writes a new counter value, which is
// derived from the counter the branch was originally predicted with. The
// table is never read back for an update. After reset the table is swept to
// INIT_STATE before any traffic is accepted.
//
// Ports
//   clk        : clock; all state changes occur on the rising edge
//   rst_n      : asynchronous active-low reset
//   lu_valid   : lookup request
//   lu_pc      : fetch PC to look up
//   pred_valid : prediction valid, one cycle after an accepted lookup
//   pred_taken : predicted direction (pred_ctr[1])
//   pred_ctr   : counter value read; held while pred_valid is low
//   up_valid   : resolved-branch update
//   up_pc      : PC of the resolved branch
//   up_taken   : actual outcome of the branch
//   up_ctr     : counter value the branch was predicted with
//   init_busy  : table sweep in progress; lookups and updates are ignored
// ---------------------------------------------------------------------------
module bimodal_pht #(
  parameter int unsigned INDEX_W    = 9,
  parameter logic [1:0]  INIT_STATE = 2'b01
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lu_valid,
  input  logic [31:0] lu_pc,
  output logic        pred_valid,
  output logic        pred_taken,
  output logic [1:0]  pred_ctr,
  input  logic        up_valid,
  input  logic [31:0] up_pc,
  input  logic        up_taken,
  input  logic [1:0]  up_ctr,
  output logic        init_busy
);

  localparam int unsigned DEPTH = 2 ** INDEX_W;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [INDEX_W-1:0] sweep_q, sweep_d;

  logic [1:0]         pht [DEPTH];

  logic [INDEX_W-1:0] lu_idx, up_idx;
  logic [1:0]         up_new;
  logic               mem_we;
  logic [INDEX_W-1:0] mem_waddr;
  logic [1:0]         mem_wdata;
  logic               lu_accept;
  logic [1:0]         rd_data;

  // The byte-offset bits and the bits above the index never select an entry.
  // They are folded into one signal only so that they count as consumed.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lu_pc[31:INDEX_W+2], lu_pc[1:0],
                            up_pc[31:INDEX_W+2], up_pc[1:0]};

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  assign lu_idx = lu_pc[INDEX_W+1:2];
  assign up_idx = up_pc[INDEX_W+1:2];

  // The new counter value comes from the counter carried down the pipe
  // (up_ctr). The table is never read to compute it, so the write completes
  // in the same cycle as up_valid.
  assign up_new = up_taken ? sat_inc(up_ctr) : sat_dec(up_ctr);

  assign init_busy = (state_q == ST_INIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  // The single write port is owned by the sweep during INIT and by the
  // update port during RUN. Lookups are accepted only in RUN.
  always_comb begin
    state_d   = state_q;
    sweep_d   = sweep_q;
    mem_we    = 1'b0;
    mem_waddr = up_idx;
    mem_wdata = up_new;
    lu_accept = 1'b0;
    case (state_q)
      ST_INIT: begin
        mem_we    = 1'b1;
        mem_waddr = sweep_q;
        mem_wdata = INIT_STATE;
        sweep_d   = sweep_q + 1'b1;
        if (sweep_q == {INDEX_W{1'b1}}) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        mem_we    = up_valid;
        lu_accept = lu_valid;
      end
      default: begin
        state_d = ST_INIT;
        sweep_d = '0;
      end
    endcase
  end

  // Write-first bypass: when an update hits the same entry in the same cycle
  // as a lookup, the lookup returns the value being written.
  assign rd_data = (mem_we && (mem_waddr == lu_idx)) ? mem_wdata : pht[lu_idx];

  always_ff @(posedge clk) begin
    if (mem_we) begin
      pht[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
      pred_ctr   <= 2'b00;
    end else begin
      pred_valid <= lu_accept;
      if (lu_accept) begin
        pred_ctr   <= rd_data;
        pred_taken <= rd_data[1];
      end
    end
  end

endmodule

// File: tb/tb_bimodal_pht.sv
// ---------------------------------------------------------------------------
// tb_bimodal_pht
// Self-checking bench for bimodal_pht. It covers the following:
//   - the reset sweep, including a reset issued in the middle of a sweep
//   - table-driven lookup and update vectors, covering training, saturation,
//     bypass, aliasing, independent ports and back-to-back updates
//   - a reset pulse issued mid-run
// Expected outputs are queued when stimulus is driven. They are popped and
// compared one cycle later.
// ---------------------------------------------------------------------------
module tb_bimodal_pht;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lu_valid;
  logic [31:0] lu_pc;
  logic        pred_valid;
  logic        pred_taken;
  logic [1:0]  pred_ctr;
  logic        up_valid;
  logic [31:0] up_pc;
  logic        up_taken;
  logic [1:0]  up_ctr;
  logic        init_busy;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic        lu_valid;
    logic [31:0] lu_pc;
    logic        up_valid;
    logic [31:0] up_pc;
    logic        up_taken;
    logic [1:0]  up_ctr;
    logic [1:0]  exp_ctr;
  } vec_t;

  typedef struct {
    logic       valid;
    logic [1:0] ctr;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  logic [1:0] last_ctr;

  always #5 clk = ~clk;

  bimodal_pht dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .lu_valid   (lu_valid),
    .lu_pc      (lu_pc),
    .pred_valid (pred_valid),
    .pred_taken (pred_taken),
    .pred_ctr   (pred_ctr),
    .up_valid   (up_valid),
    .up_pc      (up_pc),
    .up_taken   (up_taken),
    .up_ctr     (up_ctr),
    .init_busy  (init_busy)
  );

  task automatic check_val(input string name, input logic [31:0] actual,
                           input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic drive_idle();
    lu_valid = 1'b0;
    lu_pc    = '0;
    up_valid = 1'b0;
    up_pc    = '0;
    up_taken = 1'b0;
    up_ctr   = 2'b00;
  endtask

  // Drives one cycle of stimulus and queues the expected output. When no
  // lookup is issued, the counter output must hold its previous value.
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    lu_valid = v.lu_valid;
    lu_pc    = v.lu_pc;
    up_valid = v.up_valid;
    up_pc    = v.up_pc;
    up_taken = v.up_taken;
    up_ctr   = v.up_ctr;
    if (v.lu_valid) last_ctr = v.exp_ctr;
    e.valid = v.lu_valid;
    e.ctr   = last_ctr;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name);
    exp_t e;
    if (sb_q.size() == 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL %s: scoreboard empty, got pred_valid=%0b", name, pred_valid);
    end else begin
      e = sb_q.pop_front();
      check_val({name, "_valid"}, {31'b0, pred_valid}, {31'b0, e.valid});
      check_val({name, "_ctr"},   {30'b0, pred_ctr},   {30'b0, e.ctr});
      check_val({name, "_taken"}, {31'b0, pred_taken}, {31'b0, e.ctr[1]});
    end
  endtask

  // Counts the cycles from reset release until init_busy falls. During this
  // time pred_valid must never assert.
  task automatic run_sweep(input string name);
    int   n = 0;
    logic saw_valid = 1'b0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (pred_valid !== 1'b0) saw_valid = 1'b1;
    end while (init_busy === 1'b1 && n < 2000);
    check_val({name, "_cycles"}, n, 512);
    check_val({name, "_no_pred"}, {31'b0, saw_valid}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    check_val({name, "_pred_valid"}, {31'b0, pred_valid}, 32'd0);
    check_val({name, "_pred_ctr"},   {30'b0, pred_ctr},   32'd0);
    check_val({name, "_pred_taken"}, {31'b0, pred_taken}, 32'd0);
    check_val({name, "_init_busy"},  {31'b0, init_busy},  32'd1);
  endtask

  initial begin
    drive_idle();
    rst_n    = 1'b0;
    last_ctr = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");

    // Traffic is held active through the whole sweep. None of it may be
    // accepted. The update aims at entry 0x11, which is checked later.
    lu_valid = 1'b1;
    lu_pc    = 32'h0000_0040;
    up_valid = 1'b1;
    up_pc    = 32'h0000_0044;
    up_taken = 1'b1;
    up_ctr   = 2'b11;
    rst_n    = 1'b1;
    run_sweep("sweep1");
    drive_idle();

    //          lu   lu_pc          up   up_pc          tkn   up_ctr exp
    vecs.push_back('{1'b1, 32'h0000_0040, 1'b0, 32'h0,         1'b0, 2'b00, 2'b01}); // post-init read
    vecs.push_back('{1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 2'b00, 2'b00}); // idle, hold
    vecs.push_back('{1'b0, 32'h0,         1'b1, 32'h0000_0040, 1'b1, 2'b01, 2'b00}); // train 01->10
    vecs.push_back('{1'b0, 32'h0,         1'b1, 32'h0000_0040, 1'b1, 2'b10, 2'b00}); // train 10->11
    vecs.push_back('{1'b1, 32'h0000_0040, 1'b0, 32'h0,         1'b0, 2'b00, 2'b11});
    vecs.push_back('{1'b0, 32'h0,         1'b1, 32'h0000_0040, 1'b1, 2'b11, 2'b00}); // sat_inc(11)
    vecs.push_back('{1'b1, 32'h0000_0040, 1'b0, 32'h0,         1'b0, 2'b00, 2'b11});
    vecs.push_back('{1'b0, 32'h0,         1'b1, 32'h0000_0040, 1'b0, 2'b00, 2'b00}); // sat_dec(00)
    vecs.push_back('{1'b1, 32'h0000_0040, 1'b0, 32'h0,         1'b0, 2'b00, 2'b00});
    vecs.push_back('{1'b1, 32'h0000_0840, 1'b1, 32'h0000_0040, 1'b1, 2'b01, 2'b10}); // bypass, alias
    vecs.push_back('{1'b1, 32'h0000_0040, 1'b0, 32'h0,         1'b0, 2'b00, 2'b10});
    vecs.push_back('{1'b1, 32'h0000_0044, 1'b1, 32'h0000_0080, 1'b0, 2'b01, 2'b01}); // independent
    vecs.push_back('{1'b1, 32'h0000_0080, 1'b0, 32'h0,         1'b0, 2'b00, 2'b00});
    vecs.push_back('{1'b0, 32'h0,         1'b1, 32'h0000_00C0, 1'b1, 2'b10, 2'b00}); // b2b first
    vecs.push_back('{1'b0, 32'h0,         1'b1, 32'h0000_00C0, 1'b0, 2'b01, 2'b00}); // b2b last
    vecs.push_back('{1'b1, 32'h0000_00C0, 1'b0, 32'h0,         1'b0, 2'b00, 2'b00});
    vecs.push_back('{1'b1, 32'h0000_0100, 1'b1, 32'h0000_0100, 1'b0, 2'b11, 2'b10}); // bypass dec
    vecs.push_back('{1'b1, 32'h0000_0104, 1'b0, 32'h0,         1'b0, 2'b00, 2'b01});
    vecs.push_back('{1'b1, 32'h0000_0000, 1'b0, 32'h0,         1'b0, 2'b00, 2'b01}); // first entry
    vecs.push_back('{1'b1, 32'h0000_07FC, 1'b0, 32'h0,         1'b0, 2'b00, 2'b01}); // last entry
    vecs.push_back('{1'b1, 32'h0000_0040, 1'b0, 32'h0,         1'b0, 2'b00, 2'b10}); // before reset

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i));
    end
    drive_idle();

    // The reset pulse lands between clock edges. The outputs must clear
    // without waiting for an edge.
    rst_n = 1'b0;
    #2;
    check_reset_outputs("midrun_reset");
    @(posedge clk);
    #1;
    lu_valid = 1'b1;
    lu_pc    = 32'h0000_0040;
    rst_n    = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    check_val("midsweep_busy", {31'b0, init_busy}, 32'd1);

    // A reset during the sweep restarts it from entry 0.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    run_sweep("sweep2");
    drive_idle();
    last_ctr = 2'b00;

    applyStimulus('{1'b1, 32'h0000_0040, 1'b0, 32'h0, 1'b0, 2'b00, 2'b01});
    checkOutput("post_reset_read");
    applyStimulus('{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 2'b00, 2'b00});
    checkOutput("post_reset_idle");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
